// File: rtl/divider8_restoring.sv
// divider8_restoring: sequential 8-bit unsigned restoring divider.
// Computes Q = A / B and R = A % B, producing one quotient bit per cycle.
// Each trial subtraction goes through one 8-bit ripple full subtractor.
//
// Ports:
//   clk          single clock; all state updates on the rising edge
//   rst          synchronous, active-high reset
//   start        request a division; sampled only in IDLE
//   A, B         dividend and divisor, captured on an accepted start
//   Q, R         quotient and remainder; held until the next result
//   busy         high while iterating
//   done         one-cycle pulse when Q and R become valid
//   div_by_zero  set with done when the captured divisor was 0

// 8-bit ripple full subtractor: S = A - B - Cin, Cout = borrow out.
module sub8_ripple (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout
);
  logic [8:0] bw;

  assign bw[0] = Cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign S[i]    = A[i] ^ B[i] ^ bw[i];
    assign bw[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bw[i]);
  end

  assign Cout = bw[8];
endmodule

module divider8_restoring #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  // The subtractor instance is fixed at 8 bits.
  if (WIDTH != 8) begin : g_width_check
    $error("divider8_restoring: only WIDTH = 8 is supported");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] p;
  logic [2:0]       cnt;

  logic [WIDTH:0]   ps_ext;
  logic             ov;
  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             accept;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] quot_next;

  // Shift the next dividend bit into the partial remainder; ov is the bit
  // pushed out of P[7].
  assign ps_ext = {p, dividend[WIDTH-1]};
  assign ov     = ps_ext[WIDTH];
  assign ps     = ps_ext[WIDTH-1:0];

  sub8_ripple u_sub (
    .A    (ps),
    .B    (divisor),
    .Cin  (1'b0),
    .S    (diff),
    .Cout (borrow)
  );

  // With ov set the true 9-bit value exceeds 255 >= divisor, so the 8-bit
  // difference is exact even though the subtractor reports a borrow.
  assign accept    = ov | ~borrow;
  assign p_next    = accept ? diff : ps;
  assign quot_next = {dividend[WIDTH-2:0], accept};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (B == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 3'd7) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dividend    <= '0;
      divisor     <= '0;
      p           <= '0;
      cnt         <= '0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (B != '0) begin
              dividend <= A;
              divisor  <= B;
              p        <= '0;
              cnt      <= '0;
            end else begin
              Q           <= '1;
              R           <= A;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          p        <= p_next;
          dividend <= quot_next;
          cnt      <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            Q           <= quot_next;
            R           <= p_next;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divider8_restoring.sv
// Bench for divider8_restoring: directed cases with literal expectations
// plus randomized divisions, with a cycle-by-cycle behavioural model.
module tb_divider8_restoring;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A, B;
  logic [7:0] Q, R;
  logic       busy, done, div_by_zero;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  divider8_restoring #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Behavioural model: phase 0 idle, 1 computing, 2 result cycle.
  int         m_phase = 0;
  int         m_left  = 0;
  logic [7:0] m_q = 8'd0, m_r = 8'd0, pend_q = 8'd0, pend_r = 8'd0;
  logic       m_dbz = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_q = 8'd0; m_r = 8'd0; m_dbz = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          if (B == 8'd0) begin
            m_q = 8'hFF; m_r = A; m_dbz = 1'b1; m_phase = 2;
          end else begin
            pend_q = A / B; pend_r = A % B; m_left = 8; m_phase = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_q = pend_q; m_r = pend_r; m_dbz = 1'b0; m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle_outputs", {13'd0, busy, done, div_by_zero, Q, R},
            {13'd0, m_phase == 1, m_phase == 2, m_dbz, m_q, m_r});
  end

  task automatic wait_done(output bit got, output int nbusy);
    got = 0; nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
      if (busy) nbusy++;
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edbz, input int ebusy);
    bit got;
    int nb;
    @(posedge clk); #2;
    start = 1'b1; A = a; B = b;
    @(posedge clk); #2;
    start = 1'b0; A = 8'($urandom); B = 8'($urandom);
    wait_done(got, nb);
    if (got) begin
      check("Q", {24'd0, Q}, {24'd0, eq});
      check("R", {24'd0, R}, {24'd0, er});
      check("div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
      check("busy_cycles", nb, ebusy);
    end
  endtask

  initial begin
    bit got;
    int nb;
    rst = 1'b1; start = 1'b0; A = 8'd0; B = 8'd0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {13'd0, busy, done, div_by_zero, Q, R}, 32'd0);

    do_div(8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8);
    do_div(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8);
    do_div(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8);
    do_div(8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 8);
    do_div(8'd255, 8'd200, 8'd1,   8'd55,  1'b0, 8);
    do_div(8'd255, 8'd128, 8'd1,   8'd127, 1'b0, 8);
    do_div(8'h80,  8'd0,   8'hFF,  8'h80,  1'b1, 0);

    // Starts during the computation and on the result cycle are ignored.
    @(posedge clk); #2;
    start = 1'b1; A = 8'd60; B = 8'd7;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 start = 1'b1; A = 8'd1; B = 8'd1;
    @(posedge clk); #2;
    start = 1'b0; A = 8'd200; B = 8'd0;
    wait_done(got, nb);
    if (got) begin
      start = 1'b1; A = 8'd9; B = 8'd2;
      check("hs_Q", {24'd0, Q}, 32'd8);
      check("hs_R", {24'd0, R}, 32'd4);
      @(posedge clk); #2;
      start = 1'b0;
      @(negedge clk);
      check("hs_done_start_ignored", {30'd0, busy, done}, 32'd0);
    end
    do_div(8'd17, 8'd5, 8'd3, 8'd2, 1'b0, 8);

    // Reset in the middle of a division.
    @(posedge clk); #2;
    start = 1'b1; A = 8'd100; B = 8'd3;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset", {13'd0, busy, done, div_by_zero, Q, R}, 32'd0);
    do_div(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 8);

    // Randomized divisions.
    for (int k = 0; k < 120; k++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 8'd0;
        1, 2:    b = 8'($urandom_range(1, 4));
        default: b = 8'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if (b == 8'd0) do_div(a, b, 8'hFF, a, 1'b1, 0);
      else           do_div(a, b, a / b, a % b, 1'b0, 8);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
